// File: rtl/key_filter.sv
// Debounces an active-low push-button into press/release pulses,
// a stable level and a press-toggled LED.
module key_filter #(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_flag,
  output logic release_flag,
  output logic key_state,
  output logic led_out
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILTER,
    DOWN,
    RELEASE_FILTER
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             kflag_q, kflag_d;
  logic             rflag_q, rflag_d;
  logic             kstate_q, kstate_d;
  logic             led_q, led_d;

  // Two-flop synchroniser; idles high so reset looks like a released key
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Filter state, counter and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      kflag_q  <= 1'b0;
      rflag_q  <= 1'b0;
      kstate_q <= 1'b1;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kflag_q  <= kflag_d;
      rflag_q  <= rflag_d;
      kstate_q <= kstate_d;
      led_q    <= led_d;
    end
  end

  // Next-state logic: any bounce in a filter state restarts from scratch
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kflag_d  = 1'b0;
    rflag_d  = 1'b0;
    kstate_d = kstate_q;
    led_d    = led_q;
    unique case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_FILTER;
          cnt_d   = '0;
        end
      end
      PRESS_FILTER: begin
        if (sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = DOWN;
          cnt_d    = '0;
          kflag_d  = 1'b1;
          kstate_d = 1'b0;
          led_d    = ~led_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (sync2_q) begin
          state_d = RELEASE_FILTER;
          cnt_d   = '0;
        end
      end
      RELEASE_FILTER: begin
        if (!sync2_q) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = IDLE;
          cnt_d    = '0;
          rflag_d  = 1'b1;
          kstate_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign key_flag     = kflag_q;
  assign release_flag = rflag_q;
  assign key_state    = kstate_q;
  assign led_out      = led_q;

endmodule

// File: tb/tb_key_filter.sv
// Randomised and directed bench for key_filter against a
// run-length model of the debounce rules.
module tb_key_filter;

  localparam int CNT_MAX = 9;
  localparam int CNT_W   = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_flag, release_flag, key_state, led_out;

  int n_vec  = 0;
  int n_fail = 0;

  // model: raw samples delayed two edges, run of samples
  // disagreeing with the accepted level
  logic m_d1, m_d2, m_lvl, m_led, m_kf, m_rf;
  int   m_run;

  key_filter #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_in       (key_in),
    .key_flag     (key_flag),
    .release_flag (release_flag),
    .key_state    (key_state),
    .led_out      (led_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b want %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic s;
    m_kf = 1'b0;
    m_rf = 1'b0;
    if (sys_rst) begin
      m_d1  = 1'b1;
      m_d2  = 1'b1;
      m_lvl = 1'b1;
      m_led = 1'b0;
      m_run = 0;
    end else begin
      s    = m_d2;
      m_d2 = m_d1;
      m_d1 = key_in;
      if (s != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == CNT_MAX + 1) begin
        m_run = 0;
        if (m_lvl) begin
          m_kf  = 1'b1;
          m_led = ~m_led;
        end else begin
          m_rf = 1'b1;
        end
        m_lvl = ~m_lvl;
      end
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("key_flag", key_flag, m_kf);
    chk("release_flag", release_flag, m_rf);
    chk("key_state", key_state, m_lvl);
    chk("led_out", led_out, m_led);
  endtask

  task automatic drive(input logic k, input int n);
    key_in = k;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    sys_rst = 1'b0;
  endtask

  initial begin
    int len;
    logic lvl;
    m_d1 = 1'b1; m_d2 = 1'b1; m_lvl = 1'b1;
    m_led = 1'b0; m_kf = 1'b0; m_rf = 1'b0; m_run = 0;

    key_in = 1'b1;
    do_reset(3);
    drive(1'b1, 5);
    // clean press held long, then release
    drive(1'b0, 62);
    drive(1'b1, 30);
    // bounce on press
    drive(1'b0, 9);
    drive(1'b1, 2);
    drive(1'b0, 20);
    // glitch during release
    drive(1'b1, 5);
    drive(1'b0, 3);
    drive(1'b1, 20);
    // three clean press/release cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 15);
      drive(1'b1, 15);
    end
    // reset in the middle of press filtering
    drive(1'b0, 9);
    key_in = 1'b0;
    do_reset(1);
    drive(1'b0, 20);
    drive(1'b1, 20);
    // random segments, lengths straddling the threshold
    lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 39) == 0) begin
        key_in = lvl;
        do_reset($urandom_range(1, 3));
      end
      drive(lvl, len);
      lvl = ~lvl;
    end
    drive(1'b1, 20);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
